// File: rtl/y86_sequencer.sv
// Multi-cycle Y86 control sequencer: walks FETCH..PCUPD once per instruction and reports status.
// Optional feature: define Y86_MEM_WAIT_EN to stretch MEMORY until mem_ready for memory-class icodes.
module y86_sequencer #(
  parameter int COUNT_W = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [3:0]         icode,
  input  logic               instr_valid,
  input  logic               imem_error,
  input  logic               dmem_error,
  input  logic               mem_ready,
  output logic               fetch_en,
  output logic               decode_en,
  output logic               execute_en,
  output logic               memory_en,
  output logic               writeback_en,
  output logic               pc_en,
  output logic               set_cc,
  output logic [2:0]         stat,
  output logic               busy,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_PCUPD     = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] IC_HALT = 4'h0;
  localparam logic [3:0] IC_OPL  = 4'h6;

  state_t             state_q, state_d;
  logic [2:0]         stat_q, stat_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]         icode_q, icode_d;

  logic mem_op;
  logic mem_stall;

  // Instructions that touch data memory: rmmovl, mrmovl, call, ret, pushl, popl.
  assign mem_op = icode_q inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};

`ifdef Y86_MEM_WAIT_EN
  assign mem_stall = mem_op & ~mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_stall        = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      stat_q  <= STAT_AOK;
      cnt_q   <= '0;
      icode_q <= '0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      cnt_q   <= cnt_d;
      icode_q <= icode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    cnt_d   = cnt_q;
    icode_d = icode_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          stat_d  = STAT_AOK;
          cnt_d   = '0;
        end
      end
      S_FETCH: begin
        if (imem_error) begin
          state_d = S_HALT;
          stat_d  = STAT_ADR;
        end else if (!instr_valid) begin
          state_d = S_HALT;
          stat_d  = STAT_INS;
        end else begin
          state_d = S_DECODE;
          icode_d = icode;
        end
      end
      S_DECODE:  state_d = S_EXECUTE;
      S_EXECUTE: state_d = S_MEMORY;
      S_MEMORY: begin
        // dmem_error is only meaningful once the access has completed.
        if (mem_stall) begin
          state_d = S_MEMORY;
        end else if (mem_op && dmem_error) begin
          state_d = S_HALT;
          stat_d  = STAT_ADR;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_WRITEBACK: state_d = S_PCUPD;
      S_PCUPD: begin
        if (cnt_q != '1) cnt_d = cnt_q + COUNT_W'(1);
        if (icode_q == IC_HALT) begin
          state_d = S_HALT;
          stat_d  = STAT_HLT;
        end else begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fetch_en     = (state_q == S_FETCH);
  assign decode_en    = (state_q == S_DECODE);
  assign execute_en   = (state_q == S_EXECUTE);
  assign memory_en    = (state_q == S_MEMORY);
  assign writeback_en = (state_q == S_WRITEBACK);
  assign pc_en        = (state_q == S_PCUPD);
  assign set_cc       = (state_q == S_EXECUTE) && (icode_q == IC_OPL);
  assign busy         = (state_q != S_IDLE) && (state_q != S_HALT);
  assign stat         = stat_q;
  assign instr_count  = cnt_q;

endmodule

// File: tb/tb_y86_sequencer.sv
// Randomized program bench for y86_sequencer with a per-instruction expected-trace model.
// A second instance with COUNT_W=2 shares the stimulus to cover counter saturation.
module tb_y86_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n, start, instr_valid, imem_error, dmem_error, mem_ready;
  logic [3:0] icode;

  logic        fe_a, de_a, ee_a, me_a, we_a, pe_a, cc_a, busy_a;
  logic [2:0]  stat_a;
  logic [31:0] cnt_a;
  logic        fe_s, de_s, ee_s, me_s, we_s, pe_s, cc_s, busy_s;
  logic [2:0]  stat_s;
  logic [1:0]  cnt_s;

  y86_sequencer #(.COUNT_W(32)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .icode(icode),
    .instr_valid(instr_valid), .imem_error(imem_error), .dmem_error(dmem_error),
    .mem_ready(mem_ready), .fetch_en(fe_a), .decode_en(de_a), .execute_en(ee_a),
    .memory_en(me_a), .writeback_en(we_a), .pc_en(pe_a), .set_cc(cc_a),
    .stat(stat_a), .busy(busy_a), .instr_count(cnt_a)
  );

  y86_sequencer #(.COUNT_W(2)) dut_sat (
    .clock(clock), .reset_n(reset_n), .start(start), .icode(icode),
    .instr_valid(instr_valid), .imem_error(imem_error), .dmem_error(dmem_error),
    .mem_ready(mem_ready), .fetch_en(fe_s), .decode_en(de_s), .execute_en(ee_s),
    .memory_en(me_s), .writeback_en(we_s), .pc_en(pe_s), .set_cc(cc_s),
    .stat(stat_s), .busy(busy_s), .instr_count(cnt_s)
  );

  logic [6:0] en_a, en_s;
  assign en_a = {fe_a, de_a, ee_a, me_a, we_a, pe_a, cc_a};
  assign en_s = {fe_s, de_s, ee_s, me_s, we_s, pe_s, cc_s};

  localparam logic [6:0] EN_NONE = 7'b0000000;
  localparam logic [6:0] EN_F    = 7'b1000000;
  localparam logic [6:0] EN_D    = 7'b0100000;
  localparam logic [6:0] EN_E    = 7'b0010000;
  localparam logic [6:0] EN_M    = 7'b0001000;
  localparam logic [6:0] EN_W    = 7'b0000100;
  localparam logic [6:0] EN_P    = 7'b0000010;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model state: status, retired counts, and whether the program has stopped.
  logic [2:0]  stat_m = 3'd1;
  logic [31:0] cnt_m  = '0;
  logic [1:0]  sat_m  = '0;
  logic        halted = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check one cycle's outputs (inputs already driven at the negedge), then advance to next negedge.
  task automatic cyc(input logic [6:0] en_e, input logic busy_e);
    #1;
    check("enables", 64'(en_a), 64'(en_e));
    check("enables_sat", 64'(en_s), 64'(en_e));
    check("busy", 64'(busy_a), 64'(busy_e));
    check("stat", 64'(stat_a), 64'(stat_m));
    check("stat_sat", 64'(stat_s), 64'(stat_m));
    check("instr_count", 64'(cnt_a), 64'(cnt_m));
    check("instr_count_sat", 64'(cnt_s), 64'(sat_m));
    @(negedge clock);
  endtask

  task automatic retire();
    if (cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 32'd1;
    if (sat_m != 2'b11) sat_m = sat_m + 2'd1;
  endtask

  task automatic run_instr(input logic [3:0] ic, input logic valid, input logic imem,
                           input logic dmem, input int waits);
    logic is_mem;
    is_mem = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    icode = ic; instr_valid = valid; imem_error = imem;
    dmem_error = 1'($urandom); mem_ready = 1'($urandom); start = 1'($urandom);
    cyc(EN_F, 1'b1);
    if (imem) begin stat_m = 3'd3; halted = 1'b1; return; end
    if (!valid) begin stat_m = 3'd4; halted = 1'b1; return; end
    // Scramble fetch inputs: the sequencer must work from the captured icode only.
    icode = 4'($urandom); instr_valid = 1'($urandom); imem_error = 1'($urandom);
    start = 1'($urandom);
    cyc(EN_D, 1'b1);
    start = 1'($urandom);
    cyc(EN_E | ((ic == 4'h6) ? 7'b0000001 : 7'b0), 1'b1);
`ifdef Y86_MEM_WAIT_EN
    if (is_mem) begin
      for (int i = 0; i < waits; i++) begin
        mem_ready = 1'b0; dmem_error = 1'($urandom); start = 1'($urandom);
        cyc(EN_M, 1'b1);
      end
      mem_ready = 1'b1;
    end else begin
      mem_ready = 1'($urandom);
    end
`else
    if (waits < 0) $display("negative wait count %0d", waits);
    mem_ready = 1'($urandom);
`endif
    dmem_error = dmem; start = 1'($urandom);
    cyc(EN_M, 1'b1);
    if (is_mem && dmem) begin stat_m = 3'd3; halted = 1'b1; return; end
    dmem_error = 1'($urandom); mem_ready = 1'($urandom); start = 1'($urandom);
    cyc(EN_W, 1'b1);
    start = 1'($urandom);
    cyc(EN_P, 1'b1);
    retire();
    if (ic == 4'h0) begin stat_m = 3'd2; halted = 1'b1; end
  endtask

  task automatic launch();
    for (int k = 0; k < 2; k++) begin
      start = 1'b0; icode = 4'($urandom); instr_valid = 1'($urandom);
      imem_error = 1'($urandom); dmem_error = 1'($urandom); mem_ready = 1'($urandom);
      cyc(EN_NONE, 1'b0);
    end
    start = 1'b1;
    cyc(EN_NONE, 1'b0);
    stat_m = 3'd1; cnt_m = '0; sat_m = '0; halted = 1'b0;
  endtask

  initial begin
    logic [3:0] ic;
    logic       valid, imem, dmem;
    int         waits, n;

    reset_n = 1'b0; start = 1'b0; icode = '0; instr_valid = 1'b0;
    imem_error = 1'b0; dmem_error = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clock);
    cyc(EN_NONE, 1'b0);
    reset_n = 1'b1;

    for (int p = 0; p < 30; p++) begin
      launch();
      n = 0;
      while (!halted && n < 40) begin
        ic = 4'($urandom_range(1, 15));
        if ($urandom_range(0, 9) == 0) ic = 4'h0;
        valid = ($urandom_range(0, 19) != 0);
        imem  = ($urandom_range(0, 29) == 0);
        dmem  = ($urandom_range(0, 5) == 0);
        waits = $urandom_range(0, 3);
        case (p)
          0: begin ic = (n == 0) ? 4'h6 : 4'h0; valid = 1'b1; imem = 1'b0; dmem = 1'b0; end
          1: begin ic = (n < 5) ? 4'h1 : 4'h0; valid = 1'b1; imem = 1'b0; dmem = 1'b0; end
          2: begin ic = (n == 0) ? 4'h4 : 4'h0; valid = 1'b1; imem = 1'b0; dmem = 1'b0; waits = 3; end
          3: begin ic = 4'h5; valid = 1'b1; imem = 1'b0; dmem = 1'b1; end
          4: begin valid = 1'b0; imem = 1'b1; end
          5: begin valid = (n != 2); imem = 1'b0; dmem = 1'b0; ic = 4'h2; end
          default: ;
        endcase
        run_instr(ic, valid, imem, dmem, waits);
        n++;
      end
      if (!halted) run_instr(4'h0, 1'b1, 1'b0, 1'b0, 0);
    end

    // Asynchronous reset in the middle of an OPl's EXECUTE cycle.
    launch();
    run_instr(4'h3, 1'b1, 1'b0, 1'b0, 0);
    icode = 4'h6; instr_valid = 1'b1; imem_error = 1'b0; start = 1'b0;
    cyc(EN_F, 1'b1);
    cyc(EN_D, 1'b1);
    #1;
    check("exec_before_reset", 64'(en_a), 64'(EN_E | 7'b0000001));
    #2;
    reset_n = 1'b0;
    stat_m = 3'd1; cnt_m = '0; sat_m = '0;
    #1;
    check("async_enables", 64'(en_a), 64'(EN_NONE));
    check("async_enables_sat", 64'(en_s), 64'(EN_NONE));
    check("async_busy", 64'(busy_a), 64'(1'b0));
    check("async_stat", 64'(stat_a), 64'(3'd1));
    check("async_count", 64'(cnt_a), 64'(0));
    @(negedge clock);
    start = 1'b1;
    cyc(EN_NONE, 1'b0);
    reset_n = 1'b1;
    cyc(EN_NONE, 1'b0);
    halted = 1'b0;
    run_instr(4'h0, 1'b1, 1'b0, 1'b0, 0);
    start = 1'b0;
    cyc(EN_NONE, 1'b0);
    cyc(EN_NONE, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/y86_sequencer.md
Y86_SEQUENCER -- requirements
Module: y86_sequencer

Interface
REQ-001 SHALL have parameter: COUNT_W, 32, width of retired-instruction counter.
REQ-002 SHALL have ports as follows (one per line):
  clock  input  1  sole clock, all state updates on rising edge
  reset_n  input  1  asynchronous, active-low reset
  start  input  1  begin execution; sampled in IDLE and HALT only
  icode  input  4  instruction code from fetch; valid during FETCH
  instr_valid  input  1  fetch reports legal icode/ifun; valid during FETCH
  imem_error  input  1  instruction-memory address fault; valid during FETCH
  dmem_error  input  1  data-memory address fault; valid during MEMORY
  mem_ready  input  1  data-memory completion (used only with Y86_MEM_WAIT_EN)
  fetch_en  output  1  fetch stage enable
  decode_en  output  1  decode stage enable
  execute_en  output  1  execute stage enable
  memory_en  output  1  memory stage enable
  writeback_en  output  1  register-file write enable
  pc_en  output  1  PC update enable
  set_cc  output  1  condition-code register load strobe
  stat  output  3  status: 1 AOK, 2 HLT, 3 ADR, 4 INS
  busy  output  1  high in any state other than IDLE and HALT
  instr_count  output  COUNT_W  retired-instruction count

Function
REQ-003 SHALL implement states IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT.
REQ-004 SHALL drive exactly one stage enable high per stage state (fetch_en in FETCH ... pc_en in PCUPD), with all enables low in IDLE and HALT; enables are registered-state decodes with no input path.
REQ-005 SHALL go IDLE->FETCH and HALT->FETCH on start=1, setting stat to AOK and clearing instr_count on that transition.
REQ-006 SHALL capture icode into an internal icode_q at the FETCH->DECODE edge; all later decisions use icode_q only.
REQ-007 SHALL, at the end of FETCH, go to HALT with stat=ADR if imem_error=1; else HALT with stat=INS if instr_valid=0; else DECODE; imem_error has priority.
REQ-008 SHALL sequence DECODE->EXECUTE->MEMORY->WRITEBACK->PCUPD, one cycle each except as in REQ-011.
REQ-009 SHALL assert set_cc for exactly one cycle, in EXECUTE, only when icode_q=6 (OPl).
REQ-010 SHALL, at the end of MEMORY, go to HALT with stat=ADR if dmem_error=1 and icode_q is in {4,5,8,9,A,B}; WRITEBACK and PCUPD are then skipped and instr_count is not incremented.
REQ-011 SHALL, with Y86_MEM_WAIT_EN, hold MEMORY (memory_en kept high) while icode_q is in {4,5,8,9,A,B} and mem_ready=0; dmem_error is evaluated only in the cycle mem_ready=1.
REQ-012 SHALL, leaving PCUPD, increment instr_count by 1, saturating at all-ones, then go to HALT with stat=HLT if icode_q=0, else to FETCH.
REQ-013 SHALL ignore start in every state except IDLE and HALT.
REQ-014 SHALL hold stat and instr_count constant in HALT until start.

Reset
REQ-015 SHALL, on reset_n=0 at any time including mid-instruction, asynchronously force state IDLE, all enables and set_cc 0, busy 0, stat=AOK, instr_count=0, icode_q=0.
REQ-016 SHALL leave IDLE no earlier than the first rising edge after reset_n deasserts with start=1.

Configuration
REQ-017 SHALL compile the memory wait-state feature only when macro Y86_MEM_WAIT_EN is defined; without it mem_ready is ignored and MEMORY always lasts exactly one cycle.

Verification
REQ-018 Reset, start=1, icode=1 valid, no errors -> enables walk FETCH..PCUPD one cycle each, repeats every 6 cycles, instr_count=1 after cycle 6.
REQ-019 Program 6,0 (OPl then halt) -> set_cc high exactly one cycle (cycle 3), final state HALT, stat=2, instr_count=2, busy=0.
REQ-020 instr_valid=0 in FETCH -> next cycle HALT, stat=4, decode_en never asserted, instr_count unchanged.
REQ-021 icode=5, dmem_error=1 in MEMORY -> HALT, stat=3, writeback_en and pc_en never asserted; with imem_error=1 and instr_valid=0 together in FETCH -> stat=3.
REQ-022 With Y86_MEM_WAIT_EN, icode=4, mem_ready low 3 cycles -> memory_en high 4 cycles, instruction takes 9 cycles; icode=1 ignores mem_ready.
REQ-023 reset_n pulsed low during EXECUTE -> outputs zero immediately without clock, stat=1; COUNT_W=2 with 5 nops -> instr_count saturates at 3.
